// File: rtl/pipe_hazard_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_pkg
// Shared definitions for the RAW-hazard tracker:
//   - STG_EX / STG_DM : stage index constants (index 0 is the stage right after
//                       decode).
//   - reg_idx_t       : register-index type for the default 5-bit register file.
//   - sel_width()     : width of a per-port forward select that must encode
//                       "no forward" (0) plus one code per tracked stage.
// -----------------------------------------------------------------------------
package pipe_hazard_pkg;

  localparam int REG_AW_DEFAULT = 5;

  localparam int STG_EX = 0;
  localparam int STG_DM = 1;

  typedef logic [REG_AW_DEFAULT-1:0] reg_idx_t;

  // Select codes: 0 = none, s+1 = stage s, so DEPTH+1 distinct values.
  function automatic int sel_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_match_row.sv
// -----------------------------------------------------------------------------
// hazard_match_row
// Compares one decode-stage source operand against every tracked stage.
// Produces the raw per-stage hit vector and a priority-encoded forward select
// in which the youngest (lowest-index) matching stage wins.
//
// Parameters
//   REG_AW     register-index width
//   DEPTH      number of tracked stages
//   IGNORE_R0  1: index 0 never produces a hit (hard-wired zero register)
//   SELW       forward-select width, sel_width(DEPTH)
// Ports
//   rd       in   REG_AW         source register index of this read port
//   dst      in   DEPTH*REG_AW   destination index per stage, stage s at [s*REG_AW +: REG_AW]
//   vld      in   DEPTH          stage holds a register-writing instruction
//   hit      out  DEPTH          bit s = operand matches stage s
//   fwd_sel  out  SELW           0 = none, s+1 = forward from youngest matching stage s
// -----------------------------------------------------------------------------
import pipe_hazard_pkg::*;

module hazard_match_row #(
  parameter int REG_AW    = 5,
  parameter int DEPTH     = 2,
  parameter int IGNORE_R0 = 1,
  parameter int SELW      = sel_width(DEPTH)
) (
  input  logic [REG_AW-1:0]       rd,
  input  logic [DEPTH*REG_AW-1:0] dst,
  input  logic [DEPTH-1:0]        vld,
  output logic [DEPTH-1:0]        hit,
  output logic [SELW-1:0]         fwd_sel
);

  logic rd_is_r0_masked;

  always_comb begin
    rd_is_r0_masked = (IGNORE_R0 != 0) && (rd == '0);
    hit = '0;
    for (int s = 0; s < DEPTH; s++) begin
      hit[s] = vld[s] && (dst[s*REG_AW +: REG_AW] == rd) && !rd_is_r0_masked;
    end
  end

  // Scan oldest to youngest so the youngest hit is the last one written.
  always_comb begin
    fwd_sel = '0;
    for (int s = DEPTH - 1; s >= 0; s--) begin
      if (hit[s]) begin
        fwd_sel = SELW'(s + 1);
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_tracker.sv
// -----------------------------------------------------------------------------
// pipe_hazard_tracker
// Parametrised RAW-hazard tracker for the in-order pipeline. Each issued
// instruction's destination register (with valid and load tags) is shifted
// through DEPTH tracked stages (0 = EX, 1 = DM, ...). Every decode source
// operand is compared against all stages; per-stage hits and a youngest-hit
// forward select drive the EX forwarding muxes, and an optional load-use stall
// request drives the decode stall logic.
//
// Optional feature macro: LOAD_USE_STALL_EN
//   defined   : load tag tracked in stage 0; stall raised when a source operand
//               hits a load sitting in stage 0, and stage 0 takes a bubble on
//               the advancing edge while the caller holds IF/ID.
//   undefined : no load tag state, stall tied 0, stage 0 always captures decode.
//
// Parameters
//   REG_AW     register-index width
//   NUM_RD     number of source-operand read ports
//   DEPTH      tracked stages after decode, >= 1
//   IGNORE_R0  1: register index 0 never produces a hit
// Ports
//   clk         in   1               clock, rising edge
//   rst         in   1               asynchronous reset, active-low
//   en          in   1               pipeline advance enable
//   flush       in   1               kill all tracked entries
//   rd_req      in   NUM_RD*REG_AW   source indices, port p at [p*REG_AW +: REG_AW]
//   wr_req      in   REG_AW          destination index of the decode instruction
//   wr_en       in   1               decode instruction writes the register file
//   wr_is_load  in   1               decode instruction is a load
//   hit         out  NUM_RD*DEPTH    bit [p*DEPTH+s] = port p matches stage s
//   fwd_sel     out  NUM_RD*SELW     per port: 0 = none, s+1 = youngest matching stage s
//   stall       out  1               load-use stall request
// -----------------------------------------------------------------------------
import pipe_hazard_pkg::*;

module pipe_hazard_tracker #(
  parameter int REG_AW    = 5,
  parameter int NUM_RD    = 2,
  parameter int DEPTH     = 2,
  parameter int IGNORE_R0 = 1,
  localparam int SELW     = sel_width(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     flush,
  input  logic [NUM_RD*REG_AW-1:0] rd_req,
  input  logic [REG_AW-1:0]        wr_req,
  input  logic                     wr_en,
  input  logic                     wr_is_load,
  output logic [NUM_RD*DEPTH-1:0]  hit,
  output logic [NUM_RD*SELW-1:0]   fwd_sel,
  output logic                     stall
);

  // Tracked stage state; stage s occupies [s*REG_AW +: REG_AW] / bit s.
  logic [DEPTH*REG_AW-1:0] dst_p;
  logic [DEPTH-1:0]        vld_p;

  // ---- Stage shift register ----
  // Priority: flush > hold (!en) > advance. Flush only kills the tags; the
  // stale dst values can never match because their valid bits are clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dst_p <= '0;
      vld_p <= '0;
    end else if (flush) begin
      vld_p <= '0;
    end else if (en) begin
      for (int s = DEPTH - 1; s >= 1; s--) begin
        dst_p[s*REG_AW +: REG_AW] <= dst_p[(s-1)*REG_AW +: REG_AW];
        vld_p[s]                  <= vld_p[s-1];
      end
      dst_p[STG_EX*REG_AW +: REG_AW] <= wr_req;
      // A stalled decode instruction is re-presented next cycle, so the
      // entry entering stage 0 now must be a bubble.
      vld_p[STG_EX] <= wr_en & ~stall;
    end
  end

  // ---- Per-port comparison rows ----
  for (genvar p = 0; p < NUM_RD; p++) begin : g_row
    hazard_match_row #(
      .REG_AW    (REG_AW),
      .DEPTH     (DEPTH),
      .IGNORE_R0 (IGNORE_R0),
      .SELW      (SELW)
    ) u_row (
      .rd      (rd_req[p*REG_AW +: REG_AW]),
      .dst     (dst_p),
      .vld     (vld_p),
      .hit     (hit[p*DEPTH +: DEPTH]),
      .fwd_sel (fwd_sel[p*SELW +: SELW])
    );
  end

`ifdef LOAD_USE_STALL_EN
  // Only stage 0 needs the load tag: a load's result is usable by forwarding
  // once it has left EX, so older stages never cause a stall.
  logic ld_p0;

  // ---- Load tag for stage 0 ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_p0 <= 1'b0;
    end else if (flush) begin
      ld_p0 <= 1'b0;
    end else if (en) begin
      ld_p0 <= wr_is_load & wr_en & ~stall;
    end
  end

  // Independent of en so decode sees the request even while the pipe holds.
  always_comb begin
    stall = 1'b0;
    for (int p = 0; p < NUM_RD; p++) begin
      stall = stall | (hit[p*DEPTH + STG_EX] & ld_p0);
    end
  end
`else
  logic unused_load_tag;

  assign unused_load_tag = wr_is_load;
  assign stall           = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_hazard_tracker.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_tracker
// Self-checking bench for pipe_hazard_tracker with default parameters
// (REG_AW=5, NUM_RD=2, DEPTH=2, IGNORE_R0=1, so SELW=2).
// Expected outputs are pushed to a scoreboard queue as stimulus is applied and
// popped and compared once the combinational outputs have settled.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_pipe_hazard_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       flush;
  logic [9:0] rd_req;
  logic [4:0] wr_req;
  logic       wr_en;
  logic       wr_is_load;
  logic [3:0] hit;
  logic [3:0] fwd_sel;
  logic       stall;

  typedef struct {
    string      name;
    logic [3:0] hit;
    logic [3:0] fwd;
    logic       stall;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;

  pipe_hazard_tracker dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .flush      (flush),
    .rd_req     (rd_req),
    .wr_req     (wr_req),
    .wr_en      (wr_en),
    .wr_is_load (wr_is_load),
    .hit        (hit),
    .fwd_sel    (fwd_sel),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs change 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // rd_req packing helper: port1 in the upper field, port0 in the lower.
  function automatic logic [9:0] rd2(input logic [4:0] p1, input logic [4:0] p0);
    return {p1, p0};
  endfunction

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; flush = 1'b0; wr_req = 5'd0; wr_en = 1'b0; wr_is_load = 1'b0;
    rd_req = rd2(5'd0, 5'd0);
    #2;
    q.push_back('{"reset_r0", 4'b0000, 4'b0000, 1'b0});
    e = q.pop_front(); checks++;
    if (hit !== e.hit || fwd_sel !== e.fwd || stall !== e.stall) begin
      failures++;
      $display("FAIL %s: got hit=%b fwd=%b stall=%b, want hit=%b fwd=%b stall=%b", e.name, hit, fwd_sel, stall, e.hit, e.fwd, e.stall);
    end
    tick();
    rst = 1'b1;
    rd_req = rd2(5'd3, 5'd0);
    tick(); tick();
    q.push_back('{"reset_hold_en0", 4'b0000, 4'b0000, 1'b0});
    e = q.pop_front(); checks++;
    if (hit !== e.hit || fwd_sel !== e.fwd || stall !== e.stall) begin
      failures++;
      $display("FAIL %s: got hit=%b fwd=%b stall=%b, want hit=%b fwd=%b stall=%b", e.name, hit, fwd_sel, stall, e.hit, e.fwd, e.stall);
    end
  endtask

  task automatic test_ex_forward();
    // Decode writes and reads r3 in the same cycle: no self-hit.
    rd_req = rd2(5'd0, 5'd3); wr_req = 5'd3; wr_en = 1'b1; en = 1'b1;
    #1;
    q.push_back('{"no_self_hit", 4'b0000, 4'b0000, 1'b0});
    e = q.pop_front(); checks++;
    if (hit !== e.hit || fwd_sel !== e.fwd || stall !== e.stall) begin
      failures++;
      $display("FAIL %s: got hit=%b fwd=%b stall=%b, want hit=%b fwd=%b stall=%b", e.name, hit, fwd_sel, stall, e.hit, e.fwd, e.stall);
    end
    q.push_back('{"ex_fwd", 4'b0001, 4'b0001, 1'b0});
    q.push_back('{"dm_fwd", 4'b0010, 4'b0010, 1'b0});
    q.push_back('{"aged_out", 4'b0000, 4'b0000, 1'b0});
    for (int i = 0; i < 3; i++) begin
      tick();
      wr_en = 1'b0;
      e = q.pop_front(); checks++;
      if (hit !== e.hit || fwd_sel !== e.fwd || stall !== e.stall) begin
        failures++;
        $display("FAIL %s: got hit=%b fwd=%b stall=%b, want hit=%b fwd=%b stall=%b", e.name, hit, fwd_sel, stall, e.hit, e.fwd, e.stall);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_youngest_wins();
    en = 1'b1; wr_req = 5'd7; wr_en = 1'b1;
    tick(); tick();
    en = 1'b0; wr_en = 1'b0;
    rd_req = rd2(5'd7, 5'd0);
    #1;
    q.push_back('{"youngest_p1", 4'b1100, 4'b0100, 1'b0});
    e = q.pop_front(); checks++;
    if (hit !== e.hit || fwd_sel !== e.fwd || stall !== e.stall) begin
      failures++;
      $display("FAIL %s: got hit=%b fwd=%b stall=%b, want hit=%b fwd=%b stall=%b", e.name, hit, fwd_sel, stall, e.hit, e.fwd, e.stall);
    end
    rd_req = rd2(5'd7, 5'd7);
    #1;
    q.push_back('{"youngest_both", 4'b1111, 4'b0101, 1'b0});
    e = q.pop_front(); checks++;
    if (hit !== e.hit || fwd_sel !== e.fwd || stall !== e.stall) begin
      failures++;
      $display("FAIL %s: got hit=%b fwd=%b stall=%b, want hit=%b fwd=%b stall=%b", e.name, hit, fwd_sel, stall, e.hit, e.fwd, e.stall);
    end
    en = 1'b1;
    tick();
    en = 1'b0;
    q.push_back('{"bubble_behind", 4'b1010, 4'b1010, 1'b0});
    e = q.pop_front(); checks++;
    if (hit !== e.hit || fwd_sel !== e.fwd || stall !== e.stall) begin
      failures++;
      $display("FAIL %s: got hit=%b fwd=%b stall=%b, want hit=%b fwd=%b stall=%b", e.name, hit, fwd_sel, stall, e.hit, e.fwd, e.stall);
    end
  endtask

  task automatic test_r0_bubble();
    en = 1'b1; wr_req = 5'd0; wr_en = 1'b1;
    tick();
    wr_req = 5'd5; wr_en = 1'b0;
    tick();
    en = 1'b0;
    rd_req = rd2(5'd0, 5'd5);
    #1;
    q.push_back('{"r0_and_bubble", 4'b0000, 4'b0000, 1'b0});
    e = q.pop_front(); checks++;
    if (hit !== e.hit || fwd_sel !== e.fwd || stall !== e.stall) begin
      failures++;
      $display("FAIL %s: got hit=%b fwd=%b stall=%b, want hit=%b fwd=%b stall=%b", e.name, hit, fwd_sel, stall, e.hit, e.fwd, e.stall);
    end
    rd_req = rd2(5'd5, 5'd0);
    #1;
    q.push_back('{"r0_and_bubble_swap", 4'b0000, 4'b0000, 1'b0});
    e = q.pop_front(); checks++;
    if (hit !== e.hit || fwd_sel !== e.fwd || stall !== e.stall) begin
      failures++;
      $display("FAIL %s: got hit=%b fwd=%b stall=%b, want hit=%b fwd=%b stall=%b", e.name, hit, fwd_sel, stall, e.hit, e.fwd, e.stall);
    end
  endtask

  task automatic test_flush_hold();
    en = 1'b1; wr_en = 1'b1; wr_req = 5'd4;
    tick();
    wr_req = 5'd9;
    tick();
    // Held cycles present a new write that must not be captured.
    en = 1'b0; wr_req = 5'd12;
    rd_req = rd2(5'd9, 5'd4);
    #1;
    q.push_back('{"filled", 4'b0110, 4'b0110, 1'b0});
    q.push_back('{"hold1", 4'b0110, 4'b0110, 1'b0});
    q.push_back('{"hold2", 4'b0110, 4'b0110, 1'b0});
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      e = q.pop_front(); checks++;
      if (hit !== e.hit || fwd_sel !== e.fwd || stall !== e.stall) begin
        failures++;
        $display("FAIL %s: got hit=%b fwd=%b stall=%b, want hit=%b fwd=%b stall=%b", e.name, hit, fwd_sel, stall, e.hit, e.fwd, e.stall);
      end
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    rd_req = rd2(5'd9, 5'd4);
    #1;
    q.push_back('{"flush_en0", 4'b0000, 4'b0000, 1'b0});
    e = q.pop_front(); checks++;
    if (hit !== e.hit || fwd_sel !== e.fwd || stall !== e.stall) begin
      failures++;
      $display("FAIL %s: got hit=%b fwd=%b stall=%b, want hit=%b fwd=%b stall=%b", e.name, hit, fwd_sel, stall, e.hit, e.fwd, e.stall);
    end
    // Flush wins over an advance with a valid write in decode.
    en = 1'b1; wr_req = 5'd4;
    tick();
    flush = 1'b1; wr_req = 5'd9;
    tick();
    flush = 1'b0; en = 1'b0; wr_en = 1'b0;
    #1;
    q.push_back('{"flush_over_en", 4'b0000, 4'b0000, 1'b0});
    e = q.pop_front(); checks++;
    if (hit !== e.hit || fwd_sel !== e.fwd || stall !== e.stall) begin
      failures++;
      $display("FAIL %s: got hit=%b fwd=%b stall=%b, want hit=%b fwd=%b stall=%b", e.name, hit, fwd_sel, stall, e.hit, e.fwd, e.stall);
    end
  endtask

  task automatic test_async_reset();
    en = 1'b1; wr_en = 1'b1; wr_req = 5'd11;
    tick();
    en = 1'b0; wr_en = 1'b0;
    rd_req = rd2(5'd0, 5'd11);
    #1;
    q.push_back('{"pre_reset", 4'b0001, 4'b0001, 1'b0});
    e = q.pop_front(); checks++;
    if (hit !== e.hit || fwd_sel !== e.fwd || stall !== e.stall) begin
      failures++;
      $display("FAIL %s: got hit=%b fwd=%b stall=%b, want hit=%b fwd=%b stall=%b", e.name, hit, fwd_sel, stall, e.hit, e.fwd, e.stall);
    end
    // Assert reset away from any clock edge.
    #1 rst = 1'b0;
    #1;
    q.push_back('{"async_reset", 4'b0000, 4'b0000, 1'b0});
    e = q.pop_front(); checks++;
    if (hit !== e.hit || fwd_sel !== e.fwd || stall !== e.stall) begin
      failures++;
      $display("FAIL %s: got hit=%b fwd=%b stall=%b, want hit=%b fwd=%b stall=%b", e.name, hit, fwd_sel, stall, e.hit, e.fwd, e.stall);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_load_use();
    en = 1'b1; wr_en = 1'b1; wr_req = 5'd6; wr_is_load = 1'b1;
    tick();
    // Next decode instruction writes r8 and reads r6 (port0) and r8 (port1).
    en = 1'b0; wr_is_load = 1'b0; wr_req = 5'd8; wr_en = 1'b1;
    rd_req = rd2(5'd8, 5'd6);
    #1;
`ifdef LOAD_USE_STALL_EN
    q.push_back('{"load_use_stall", 4'b0001, 4'b0001, 1'b1});
    q.push_back('{"stall_bubble", 4'b0010, 4'b0010, 1'b0});
`else
    q.push_back('{"load_no_stall", 4'b0001, 4'b0001, 1'b0});
    q.push_back('{"load_advance", 4'b0110, 4'b0110, 1'b0});
`endif
    e = q.pop_front(); checks++;
    if (hit !== e.hit || fwd_sel !== e.fwd || stall !== e.stall) begin
      failures++;
      $display("FAIL %s: got hit=%b fwd=%b stall=%b, want hit=%b fwd=%b stall=%b", e.name, hit, fwd_sel, stall, e.hit, e.fwd, e.stall);
    end
    en = 1'b1;
    tick();
    en = 1'b0; wr_en = 1'b0;
    e = q.pop_front(); checks++;
    if (hit !== e.hit || fwd_sel !== e.fwd || stall !== e.stall) begin
      failures++;
      $display("FAIL %s: got hit=%b fwd=%b stall=%b, want hit=%b fwd=%b stall=%b", e.name, hit, fwd_sel, stall, e.hit, e.fwd, e.stall);
    end
  endtask

  initial begin
    test_reset();
    test_ex_forward();
    test_youngest_wins();
    test_r0_bubble();
    test_flush_hold();
    test_async_reset();
    test_load_use();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
